// File: rtl/circular_fifo_arbiter.sv
// circular_fifo_arbiter
// Shares one power-of-two circular FIFO between NUM_REQ packet producers.
// A round-robin scheduler grants one producer at a time and holds the grant
// for a whole packet, so packets never interleave in the buffer. A single
// valid/ready stream drains the buffer in order.
//
// Optional feature: define CIRCULAR_FIFO_ARB_SRC_TAG_EN to store the source
// index with every entry and expose it on out_src.
//
// BUFFER_SIZE is rounded up to D = 2**clog2(BUFFER_SIZE) and must be >= 2.
// NUM_REQ must be in 2..16.
module circular_fifo_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 512,
  parameter int BUFFER_SIZE = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
`ifdef CIRCULAR_FIFO_ARB_SRC_TAG_EN
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] out_src,
`endif
  input  logic                              out_ready,
  output logic [$clog2(BUFFER_SIZE):0]      occupancy
);

  // Pointer index width, rounded-up depth and source-index width.
  localparam int A = $clog2(BUFFER_SIZE);
  localparam int D = 1 << A;
  localparam int S = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t         state;
  logic [S-1:0]   grant;
  logic [S-1:0]   rr;
  logic [S-1:0]   pick;
  logic           pick_found;
  int             scan_idx;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [A:0]     wr_ptr;
  logic [A:0]     rd_ptr;
  logic           full;
  logic           empty;
  logic           wr_en;
  logic           rd_en;

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;

  // Entry storage: data, end-of-packet flag and (optionally) source index.
  logic [DATA_WIDTH-1:0] mem_data [D];
  logic                  mem_last [D];
`ifdef CIRCULAR_FIFO_ARB_SRC_TAG_EN
  logic [S-1:0]          mem_src  [D];
`endif

  // ---------------------------------------------------------------------
  // Occupancy and status, all derived from the registered pointers so that
  // out_ready never reaches req_ready combinationally.
  // ---------------------------------------------------------------------
  assign occupancy = wr_ptr - rd_ptr;
  assign full      = occupancy[A];
  assign empty     = (occupancy == '0);

  // Round-robin search: first asserted req_valid scanning rr, rr+1, ... mod NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before the loop; without it a
    // path that assigns nothing would infer a latch.
    pick       = rr;
    pick_found = 1'b0;
    scan_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(rr) + k) % NUM_REQ;
      if (!pick_found && req_valid[scan_idx]) begin
        pick       = S'(scan_idx);
        pick_found = 1'b1;
      end
    end
  end

  // Ready is offered only to the locked producer, and only while not full.
  always_comb begin
    req_ready = '0;
    if (state == LOCKED && !full) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Write and read strobes for this cycle.
  assign wr_en   = (state == LOCKED) && req_valid[grant] && !full;
  assign rd_en   = !empty && out_ready;

  // Beat presented by the granted producer.
  assign wr_data = req_data[grant*DATA_WIDTH +: DATA_WIDTH];
  assign wr_last = req_last[grant];

  // Scheduler FSM: pick a winner in IDLE, hold it until its last beat lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is assigned with <= so every register
      // samples the pre-edge values regardless of statement order.
      state <= IDLE;
      grant <= '0;
      rr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (wr_en && wr_last) begin
            state <= IDLE;
            if (int'(grant) == NUM_REQ - 1) begin
              rr <= '0;
            end else begin
              rr <= grant + S'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write and read pointers; both may advance in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Entry write at the low bits of wr_ptr.
  // NOTE: the storage array has no reset; its contents are don't-care until
  // written, and the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr[A-1:0]] <= wr_data;
      mem_last[wr_ptr[A-1:0]] <= wr_last;
`ifdef CIRCULAR_FIFO_ARB_SRC_TAG_EN
      mem_src[wr_ptr[A-1:0]]  <= grant;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Read side: head entry driven straight from storage.
  // ---------------------------------------------------------------------
  assign out_valid = !empty;
  assign out_data  = mem_data[rd_ptr[A-1:0]];
  assign out_last  = mem_last[rd_ptr[A-1:0]];
`ifdef CIRCULAR_FIFO_ARB_SRC_TAG_EN
  assign out_src   = mem_src[rd_ptr[A-1:0]];
`endif

endmodule

// File: tb/tb_circular_fifo_arbiter.sv
// Testbench for circular_fifo_arbiter: directed packets per producer, a
// scoreboard queue of expected head beats, and a negedge monitor that checks
// every drained beat plus occupancy against a write/read count model.
module tb_circular_fifo_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int BS = 10;   // rounds up to 16 entries
  localparam int AW = 4;
  localparam int SW = 2;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_last  = '0;
  logic [NR*DW-1:0]  req_data  = '0;
  logic [NR-1:0]     req_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic [AW:0]       occupancy;
`ifdef CIRCULAR_FIFO_ARB_SRC_TAG_EN
  logic [SW-1:0]     out_src;
`endif

  always #5 clk = ~clk;

  circular_fifo_arbiter #(
    .NUM_REQ     (NR),
    .DATA_WIDTH  (DW),
    .BUFFER_SIZE (BS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef CIRCULAR_FIFO_ARB_SRC_TAG_EN
    .out_src   (out_src),
`endif
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [SW-1:0] src;
  } beat_t;

  beat_t         pq [NR][$];   // beats each producer still has to offer
  beat_t         exp_q [$];    // expected drain order
  int            n_checks = 0;
  int            n_errors = 0;
  int            exp_occ  = 0;
  logic [NR-1:0] fire_s   = '0;
  int            rmode    = 0; // 0 low, 1 high, 2 toggle, 3 one-cycle pulse

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue a packet on producer p; optionally also expect it in this order.
  task automatic send(input int p, input int len, input logic [DW-1:0] base, input bit push_exp);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = base + DW'(i);
      b.last = (i == len - 1);
      b.src  = SW'(p);
      pq[p].push_back(b);
      if (push_exp) exp_q.push_back(b);
    end
  endtask

  task automatic expect_pkt(input int p, input int len, input logic [DW-1:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = base + DW'(i);
      b.last = (i == len - 1);
      b.src  = SW'(p);
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_all();
    fire_s = '0;
    for (int i = 0; i < NR; i++) pq[i].delete();
    exp_q.delete();
  endtask

  // Called at a negedge: hold reset for two cycles, release on a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit producers_busy();
    for (int i = 0; i < NR; i++) if (pq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() > 0 || producers_busy() || occupancy != '0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, (c < budget), 1'b1);
  endtask

  // Producer and consumer driver: updates inputs 1 time unit after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (fire_s[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      end
      fire_s = '0;
      for (int i = 0; i < NR; i++) begin
        if (pq[i].size() > 0) begin
          req_valid[i]            = 1'b1;
          req_data[i*DW +: DW]    = pq[i][0].data;
          req_last[i]             = pq[i][0].last;
        end else begin
          req_valid[i]            = 1'b0;
          req_last[i]             = 1'b0;
        end
      end
      case (rmode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        2: out_ready = ~out_ready;
        default: begin
          out_ready = 1'b1;
          rmode     = 0;
        end
      endcase
    end
  end

  // Monitor: scoreboard compare on every drained beat, occupancy model check.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      exp_occ = 0;
      fire_s  = '0;
    end else begin
      check("occupancy", 64'(occupancy), 64'(exp_occ));
      check("out_valid", out_valid, (exp_occ != 0));
      check("ready_onehot", $onehot0(req_ready), 1'b1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
`ifdef CIRCULAR_FIFO_ARB_SRC_TAG_EN
          check("out_src", out_src, e.src);
`endif
        end
      end
      fire_s  = req_valid & req_ready;
      exp_occ = exp_occ + ((|fire_s) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    end
  end

  // Per-cycle table for the first packet: req_ready, occupancy, out_valid.
  logic [NR-1:0] t1_rdy [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
  int            t1_occ [6] = '{0, 0, 1, 1, 1, 0};
  logic          t1_ov  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    // Reset state, during and just after reset.
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_occupancy", occupancy, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, '0);

    // Single 3-beat packet from producer 2 with the consumer always ready.
    rmode = 1;
    send(2, 3, 32'hA, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t1_req_ready_c%0d", c + 1), req_ready, t1_rdy[c]);
      check($sformatf("t1_occupancy_c%0d", c + 1), occupancy, t1_occ[c]);
      check($sformatf("t1_out_valid_c%0d", c + 1), out_valid, t1_ov[c]);
    end
    wait_drain("t1_drain", 20);

    // Three producers with two 2-beat packets each: order 0,1,3,0,1,3.
    do_reset();
    rmode = 1;
    send(0, 2, 32'h100, 1'b0);
    send(0, 2, 32'h110, 1'b0);
    send(1, 2, 32'h200, 1'b0);
    send(1, 2, 32'h210, 1'b0);
    send(3, 2, 32'h300, 1'b0);
    send(3, 2, 32'h310, 1'b0);
    expect_pkt(0, 2, 32'h100);
    expect_pkt(1, 2, 32'h200);
    expect_pkt(3, 2, 32'h300);
    expect_pkt(0, 2, 32'h110);
    expect_pkt(1, 2, 32'h210);
    expect_pkt(3, 2, 32'h310);
    wait_drain("t2_drain", 100);

    // Fill to 16 with the consumer stalled, then a single read while full.
    do_reset();
    rmode = 0;
    send(1, 20, 32'h1000, 1'b1);
    repeat (25) @(negedge clk);
    check("full_occupancy", occupancy, 5'd16);
    check("full_req_ready", req_ready, '0);
    rmode = 3;
    @(negedge clk);
    check("full_read_cycle_occ", occupancy, 5'd16);
    check("full_read_cycle_rdy", req_ready, '0);
    @(negedge clk);
    check("after_read_occ", occupancy, 5'd15);
    check("after_read_rdy", req_ready, 4'b0010);
    @(negedge clk);
    check("refill_occ", occupancy, 5'd16);
    check("refill_rdy", req_ready, '0);
    rmode = 1;
    wait_drain("t3_drain", 100);

    // 40 beats from producer 3 with the consumer toggling; pointers wrap.
    rmode = 2;
    send(3, 20, 32'h2000, 1'b1);
    send(3, 20, 32'h3000, 1'b1);
    wait_drain("t4_drain", 300);

    // Move rr to 2, then reset mid-packet at occupancy 5.
    rmode = 1;
    send(1, 1, 32'h40, 1'b1);
    wait_drain("t5_pre_drain", 20);
    rmode = 0;
    send(2, 8, 32'h50, 1'b0);
    repeat (7) @(negedge clk);
    check("t5_occ_before_reset", occupancy, 5'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_req_ready", req_ready, '0);
    check("async_rst_occupancy", occupancy, '0);
    clear_all();
    send(3, 1, 32'h70, 1'b0);
    send(0, 1, 32'h60, 1'b0);
    expect_pkt(0, 1, 32'h60);
    expect_pkt(3, 1, 32'h70);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rmode = 1;
    wait_drain("t5_drain", 30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
